// File: rtl/pkt_hdr_strip_if.sv
// ---------------------------------------------------------------------------
// pkt_hdr_strip_if -- byte-stream bundle for the header stripper.
//
// Signals:
//   din[7:0]   byte stream in; the din_sop byte is the length header N
//   din_vld    din / din_sop / din_eop are valid this cycle
//   din_sop    header byte marker
//   din_eop    last payload byte marker
//   dout[7:0]  payload byte with the header removed
//   dout_vld   dout valid
//   dout_sop   first payload byte of the packet
//   dout_eop   last payload byte of the packet
//   err        one-cycle length/framing error pulse
//
// Modports:
//   master  traffic source / sink (drives din side, observes dout side)
//   slave   the stripper (observes din side, drives dout side and err)
// ---------------------------------------------------------------------------
interface pkt_hdr_strip_if;
    logic [7:0] din;
    logic       din_vld;
    logic       din_sop;
    logic       din_eop;
    logic [7:0] dout;
    logic       dout_vld;
    logic       dout_sop;
    logic       dout_eop;
    logic       err;

    modport master (
        output din, din_vld, din_sop, din_eop,
        input  dout, dout_vld, dout_sop, dout_eop, err
    );

    modport slave (
        input  din, din_vld, din_sop, din_eop,
        output dout, dout_vld, dout_sop, dout_eop, err
    );
endinterface

// File: rtl/pkt_hdr_strip.sv
// ---------------------------------------------------------------------------
// pkt_hdr_strip -- removes the one-byte length header from each packet of a
// byte stream and forwards the payload with one clock of latency.
//
// Ports:
//   clk    rising-edge clock for all state
//   rst_n  asynchronous reset, active low
//   bus    pkt_hdr_strip_if.slave: din/din_vld/din_sop/din_eop in,
//          dout/dout_vld/dout_sop/dout_eop/err out (all outputs registered)
//
// Configuration:
//   PKT_LEN_CHK_EN  when defined, payload length is checked against the
//                   header: an early eop or a missing eop raises err, and
//                   bytes past the declared length are dropped (DROP state).
//                   Undefined (default): packets end only on din_eop.
// ---------------------------------------------------------------------------
module pkt_hdr_strip (
    input  logic              clk,
    input  logic              rst_n,
    pkt_hdr_strip_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [7:0] len, len_nxt;
    logic [7:0] dout_nxt;
    logic       vld_nxt, sop_nxt, eop_nxt, err_nxt;

    // NOTE: every signal assigned in this block gets a default first so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        len_nxt   = len;
        dout_nxt  = 8'h00;
        vld_nxt   = 1'b0;
        sop_nxt   = 1'b0;
        eop_nxt   = 1'b0;
        err_nxt   = 1'b0;

        if (bus.din_vld) begin
            if (bus.din_sop) begin
                // A header is accepted from any state. Arriving in DATA means
                // the previous packet never saw its eop.
                len_nxt = bus.din;
                cnt_nxt = 8'h00;
                if (state == DATA)
                    err_nxt = 1'b1;
                if (bus.din != 8'h00 && !bus.din_eop) begin
                    state_nxt = DATA;
                end else begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end else begin
                unique case (state)
                    IDLE: ; // stray bytes outside a packet are discarded
                    DATA: begin
                        dout_nxt = bus.din;
                        vld_nxt  = 1'b1;
                        sop_nxt  = (cnt == 8'h00);
                        cnt_nxt  = cnt + 8'd1;
                        if (bus.din_eop) begin
                            eop_nxt   = 1'b1;
                            state_nxt = IDLE;
`ifdef PKT_LEN_CHK_EN
                            // Early eop: fewer bytes than the header promised.
                            if (({1'b0, cnt} + 9'd1) < {1'b0, len})
                                err_nxt = 1'b1;
`endif
                        end
`ifdef PKT_LEN_CHK_EN
                        else if (cnt == len - 8'd1) begin
                            // Declared length reached without eop: close the
                            // packet here and drop the excess bytes.
                            eop_nxt   = 1'b1;
                            err_nxt   = 1'b1;
                            state_nxt = DROP;
                        end
`endif
                    end
                    DROP: begin
                        if (bus.din_eop)
                            state_nxt = IDLE;
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: all state here is plain flops (no memory array), so every
    // register is cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 8'h00;
            len          <= 8'h00;
            bus.dout     <= 8'h00;
            bus.dout_vld <= 1'b0;
            bus.dout_sop <= 1'b0;
            bus.dout_eop <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            len          <= len_nxt;
            bus.dout     <= dout_nxt;
            bus.dout_vld <= vld_nxt;
            bus.dout_sop <= sop_nxt;
            bus.dout_eop <= eop_nxt;
            bus.err      <= err_nxt;
        end
    end

endmodule

// File: tb/tb_pkt_hdr_strip.sv
// ---------------------------------------------------------------------------
// tb_pkt_hdr_strip -- directed self-checking bench for pkt_hdr_strip.
// Each beat drives one input cycle and, #1 after the capturing edge, checks
// the registered outputs {err, dout_vld, dout_sop, dout_eop, dout} against a
// hand-computed value. Builds with or without PKT_LEN_CHK_EN.
// ---------------------------------------------------------------------------
module tb_pkt_hdr_strip;

`ifdef PKT_LEN_CHK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    pkt_hdr_strip_if bus ();

    pkt_hdr_strip dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%03h expected 0x%03h", tag, got, exp);
        end
    endtask

    // Packs the expected output tuple as {err, vld, sop, eop, dout}.
    function automatic logic [11:0] o(input logic e, input logic v,
                                      input logic s, input logic p,
                                      input logic [7:0] d);
        return {e, v, s, p, d};
    endfunction

    function automatic logic [11:0] outs();
        return {bus.err, bus.dout_vld, bus.dout_sop, bus.dout_eop, bus.dout};
    endfunction

    // Drive one input cycle, let the edge capture it, check the result.
    task automatic beat(input string tag, input logic [7:0] d,
                        input logic v, input logic s, input logic e,
                        input logic [11:0] exp);
        bus.din     = d;
        bus.din_vld = v;
        bus.din_sop = s;
        bus.din_eop = e;
        @(posedge clk);
        #1;
        check(tag, {20'h0, outs()}, {20'h0, exp});
        bus.din     = 8'h00;
        bus.din_vld = 1'b0;
        bus.din_sop = 1'b0;
        bus.din_eop = 1'b0;
    endtask

    localparam logic [11:0] NONE = 12'h000;

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        bus.din     = 8'h00;
        bus.din_vld = 1'b0;
        bus.din_sop = 1'b0;
        bus.din_eop = 1'b0;
        rst_n       = 1'b1;
        #2 rst_n    = 1'b0;
        #1;
        check("reset_outputs", {20'h0, outs()}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Stray bytes in IDLE are silently discarded.
        beat("idle_stray",     8'hEE, 1, 0, 0, NONE);
        beat("idle_stray_eop", 8'hEF, 1, 0, 1, NONE);

        // 3-byte packet, back to back.
        beat("p3_hdr", 8'h03, 1, 1, 0, NONE);
        beat("p3_b0",  8'hAA, 1, 0, 0, o(0, 1, 1, 0, 8'hAA));
        beat("p3_b1",  8'hBB, 1, 0, 0, o(0, 1, 0, 0, 8'hBB));
        beat("p3_b2",  8'hCC, 1, 0, 1, o(0, 1, 0, 1, 8'hCC));
        beat("p3_idle", 8'h00, 0, 0, 0, NONE);

        // 1-byte payload: sop and eop together.
        beat("p1_hdr", 8'h01, 1, 1, 0, NONE);
        beat("p1_b0",  8'h5A, 1, 0, 1, o(0, 1, 1, 1, 8'h5A));

        // Header 4, only 2 bytes with gaps; early eop flagged when checking.
        beat("p4_hdr",  8'h04, 1, 1, 0, NONE);
        beat("p4_b0",   8'h11, 1, 0, 0, o(0, 1, 1, 0, 8'h11));
        beat("p4_gap0", 8'h99, 0, 0, 0, NONE);
        beat("p4_gap1", 8'h99, 0, 1, 1, NONE);
        beat("p4_b1",   8'h22, 1, 0, 1, o(CHK, 1, 0, 1, 8'h22));

`ifdef PKT_LEN_CHK_EN
        // Header 2 with 4 bytes: closed after 2, rest dropped.
        beat("ovr_hdr", 8'h02, 1, 1, 0, NONE);
        beat("ovr_b0",  8'h01, 1, 0, 0, o(0, 1, 1, 0, 8'h01));
        beat("ovr_b1",  8'h02, 1, 0, 0, o(1, 1, 0, 1, 8'h02));
        beat("ovr_b2",  8'h03, 1, 0, 0, NONE);
        beat("ovr_b3",  8'h04, 1, 0, 1, NONE);
        beat("ovr_after", 8'h77, 1, 0, 0, NONE);
`else
        // Length not checked: 3 bytes under a header of 2 all pass through.
        beat("ovr_hdr", 8'h02, 1, 1, 0, NONE);
        beat("ovr_b0",  8'h01, 1, 0, 0, o(0, 1, 1, 0, 8'h01));
        beat("ovr_b1",  8'h02, 1, 0, 0, o(0, 1, 0, 0, 8'h02));
        beat("ovr_b2",  8'h03, 1, 0, 1, o(0, 1, 0, 1, 8'h03));
`endif
        beat("nxt_hdr", 8'h01, 1, 1, 0, NONE);
        beat("nxt_b0",  8'h77, 1, 0, 1, o(0, 1, 1, 1, 8'h77));

        // Missing eop: new header inside DATA raises err, then processed.
        beat("me_hdr",  8'h03, 1, 1, 0, NONE);
        beat("me_b0",   8'h10, 1, 0, 0, o(0, 1, 1, 0, 8'h10));
        beat("me_b1",   8'h20, 1, 0, 0, o(0, 1, 0, 0, 8'h20));
        beat("me_hdr2", 8'h01, 1, 1, 0, o(1, 0, 0, 0, 8'h00));
        beat("me_b2",   8'h30, 1, 0, 1, o(0, 1, 1, 1, 8'h30));

        // Bad headers: zero length, and eop on the header itself.
        beat("hdr_zero", 8'h00, 1, 1, 0, o(1, 0, 0, 0, 8'h00));
        beat("hdr_zero_after", 8'h44, 1, 0, 0, NONE);
        beat("hdr_eop",  8'h05, 1, 1, 1, o(1, 0, 0, 0, 8'h00));
        beat("hdr_eop_after", 8'h45, 1, 0, 0, NONE);

        // Reset mid-packet: outputs clear asynchronously, tail is ignored.
        beat("rst_hdr", 8'h03, 1, 1, 0, NONE);
        beat("rst_b0",  8'h10, 1, 0, 0, o(0, 1, 1, 0, 8'h10));
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_clear", {20'h0, outs()}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_held", {20'h0, outs()}, 32'h0);
        rst_n = 1'b1;
        beat("rst_tail0", 8'h20, 1, 0, 0, NONE);
        beat("rst_tail1", 8'h30, 1, 0, 1, NONE);
        beat("rst_nxt_hdr", 8'h02, 1, 1, 0, NONE);
        beat("rst_nxt_b0",  8'h61, 1, 0, 0, o(0, 1, 1, 0, 8'h61));
        beat("rst_nxt_b1",  8'h62, 1, 0, 1, o(0, 1, 0, 1, 8'h62));
        beat("final_idle",  8'h00, 0, 0, 0, NONE);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pkt_hdr_strip.md
PKT_HDR_STRIP -- requirements
Module: pkt_hdr_strip

Interface
REQ-001 SHALL have a single clock and an asynchronous active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous reset, active low.
REQ-004 din  input  8  byte stream; first byte of each packet (din_sop) is the length header N = payload byte count.
REQ-005 din_vld  input  1  din, din_sop and din_eop are valid this cycle.
REQ-006 din_sop  input  1  header byte marker; only meaningful with din_vld.
REQ-007 din_eop  input  1  last payload byte marker; only meaningful with din_vld.
REQ-008 dout  output  8  payload byte with the header removed; registered.
REQ-009 dout_vld  output  1  dout valid; registered.
REQ-010 dout_sop  output  1  first payload byte of the packet; registered.
REQ-011 dout_eop  output  1  last payload byte of the packet; registered.
REQ-012 err  output  1  one-cycle length/framing error pulse; registered.

Function
REQ-013 SHALL implement states IDLE, DATA and DROP, held in a registered state variable.
REQ-014 IDLE: on din_vld&&din_sop, latch len=din and clear the 8-bit payload counter cnt; go to DATA if din!=0 and din_eop=0; otherwise raise err and stay in IDLE; no dout_vld for the header.
REQ-015 IDLE: din_vld without din_sop SHALL be discarded silently.
REQ-016 DATA: each din_vld without din_sop SHALL produce dout=din and dout_vld=1 exactly one cycle later, then cnt increments.
REQ-017 dout_sop SHALL be 1 only on the first payload byte after the header (cnt==0).
REQ-018 DATA: on din_vld&&din_eop, emit the byte with dout_eop=1 and return to IDLE.
REQ-019 Bytes with din_vld=0 SHALL leave state, cnt and len unchanged; gaps are allowed anywhere inside a packet.
REQ-020 DATA: din_vld&&din_sop (missing eop) SHALL raise err, emit nothing for that byte, and be processed as a new header per REQ-014.
REQ-021 Latency is exactly 1 clock from an accepted payload byte to dout; no backpressure exists.
REQ-022 dout_sop and dout_eop SHALL both be 1 for a 1-byte payload (N=1, eop on first payload byte).
REQ-023 dout, dout_sop and dout_eop SHALL be 0 whenever dout_vld=0.

Reset
REQ-024 rst_n low SHALL force state=IDLE, cnt=0, len=0, dout=0, dout_vld=0, dout_sop=0, dout_eop=0, err=0, asynchronously.
REQ-025 Reset mid-packet SHALL discard the packet; after release the remaining bytes are ignored until the next din_sop.

Configuration
REQ-026 Macro PKT_LEN_CHK_EN SHALL enable the length check.
REQ-027 With PKT_LEN_CHK_EN: in DATA, when the byte with cnt==len-1 arrives without din_eop, emit it with dout_eop=1 and err=1 and enter DROP.
REQ-028 With PKT_LEN_CHK_EN: din_eop arriving with cnt+1<len SHALL emit dout_eop=1 together with err=1.
REQ-029 With PKT_LEN_CHK_EN: DROP discards bytes until din_vld&&din_eop (to IDLE) or din_vld&&din_sop (new header per REQ-014).
REQ-030 Without PKT_LEN_CHK_EN: len is not compared, DROP is unreachable, and packets end only on din_eop; err is raised only by REQ-014/REQ-020.

Verification
REQ-031 Header 0x03, payload AA BB CC (eop on CC), back-to-back -> dout AA/BB/CC one cycle later, sop on AA, eop on CC, err=0.
REQ-032 Header 0x01, payload 5A with eop -> one dout beat 5A, sop=eop=1, err=0.
REQ-033 Header 0x04, payload 11 22 with din_vld gaps of 2 cycles, eop on 22 -> 11, 22 emitted with gaps preserved; err=1 with eop on 22 only when PKT_LEN_CHK_EN is set.
REQ-034 PKT_LEN_CHK_EN set, header 0x02, payload 01 02 03 04 with eop on 04 -> dout 01 (sop), 02 (eop, err=1), 03/04 dropped, next packet accepted normally.
REQ-035 Header 0x03, payload 10 20, then new din_sop header 0x01 + 30 with eop -> err pulse on the second header, then 30 with sop=eop=1.
REQ-036 rst_n asserted after header 0x03 and byte 10, released before 20 30 -> all outputs 0 during reset, 20 30 ignored, next packet processed normally.
